// File: rtl/msp430_pkg.sv
// msp430_pkg: shared state encoding and access-type constants for the memory controller.
package msp430_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-to-RAM access sequencer with byte/word formatting and fixed latency.
// Define MEM_CTRL_ALIGN_ERR_EN to add the err port and reject odd word addresses.
module mem_ctrl
  import msp430_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        bw,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        rdy,
  output logic [15:0] rdata,
`ifdef MEM_CTRL_ALIGN_ERR_EN
  output logic        err,
`endif
  output logic [15:0] ram_addr,
  output logic [15:0] ram_Din,
  output logic        ram_RW,
  output logic        BW,
  input  logic [15:0] ram_out
);
  state_t state, state_nxt;
  logic we_q, bw_q, mis;
  logic [15:0] addr_q, wdata_q;
`ifdef MEM_CTRL_ALIGN_ERR_EN
  assign mis = bw_q == ACC_WORD && addr_q[0];
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE    ? (req ? ACCESS : IDLE) :
                state == ACCESS  ? ((we_q == RW_WRITE || mis) ? DONE : CAPTURE) :
                state == CAPTURE ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= RW_READ;
      bw_q    <= ACC_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      we_q    <= we;
      bw_q    <= bw;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (state == CAPTURE) rdata <= bw_q == ACC_BYTE ? {8'h00, ram_out[7:0]} : ram_out;
  // Captured fields reset to zero, so the RAM-side outputs read zero out of reset.
  always_comb begin
    busy     = state != IDLE;
    rdy      = state == DONE;
    ram_RW   = state == ACCESS && we_q == RW_WRITE && !mis;
    BW       = bw_q;
    ram_addr = bw_q == ACC_BYTE ? addr_q : {addr_q[15:1], 1'b0};
    ram_Din  = bw_q == ACC_BYTE ? {8'h00, wdata_q[7:0]} : wdata_q;
  end
`ifdef MEM_CTRL_ALIGN_ERR_EN
  assign err = rdy && mis;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte-addressed RAM model.
module tb_mem_ctrl;
  logic clk = 0, rst_n = 0, req = 0, we = 0, bw = 0;
  logic [15:0] addr = 0, wdata = 0;
  logic busy, rdy, ram_RW, BW;
  logic [15:0] rdata, ram_addr, ram_Din, ram_out;
`ifdef MEM_CTRL_ALIGN_ERR_EN
  logic err;
`endif
  int total = 0, bad = 0;
  logic [7:0] mem [65536];

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .bw(bw), .addr(addr), .wdata(wdata),
    .busy(busy), .rdy(rdy), .rdata(rdata),
`ifdef MEM_CTRL_ALIGN_ERR_EN
    .err(err),
`endif
    .ram_addr(ram_addr), .ram_Din(ram_Din), .ram_RW(ram_RW), .BW(BW), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  assign ram_out = {mem[16'(ram_addr + 16'd1)], mem[ram_addr]};
  always @(posedge clk)
    if (ram_RW) begin
      mem[ram_addr] <= ram_Din[7:0];
      if (!BW) mem[16'(ram_addr + 16'd1)] <= ram_Din[15:8];
    end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    req = 1; we = w; bw = b; addr = a; wdata = d;
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_ram_RW", ram_RW, 0);
    chk("rst_BW", BW, 0);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_ram_Din", ram_Din, 16'h0000);
    @(negedge clk); rst_n = 1;
    #1;
    // word write 0204 <- BEEF
    issue(1, 0, 16'h0204, 16'hBEEF);
    step();
    chk("ww_busy", busy, 1);
    chk("ww_RW", ram_RW, 1);
    chk("ww_addr", ram_addr, 16'h0204);
    chk("ww_din", ram_Din, 16'hBEEF);
    chk("ww_BW", BW, 0);
    chk("ww_rdy_early", rdy, 0);
    req = 0;
    step();
    chk("ww_rdy", rdy, 1);
    chk("ww_RW_off", ram_RW, 0);
    step();
    chk("ww_rdy_off", rdy, 0);
    chk("ww_idle", busy, 0);
    // word read 0204
    issue(0, 0, 16'h0204, 16'h0000);
    step();
    chk("wr_RW", ram_RW, 0);
    chk("wr_addr", ram_addr, 16'h0204);
    req = 0;
    step();
    chk("wr_rdy_early", rdy, 0);
    chk("wr_addr_hold", ram_addr, 16'h0204);
    step();
    chk("wr_rdy", rdy, 1);
    chk("wr_rdata", rdata, 16'hBEEF);
    step();
    chk("wr_rdy_off", rdy, 0);
    // byte write 0205 <- A5
    issue(1, 1, 16'h0205, 16'h12A5);
    step();
    chk("bw_RW", ram_RW, 1);
    chk("bw_addr", ram_addr, 16'h0205);
    chk("bw_din", ram_Din, 16'h00A5);
    chk("bw_BW", BW, 1);
    req = 0;
    step();
    chk("bw_rdy", rdy, 1);
    step();
    // byte read 0205
    issue(0, 1, 16'h0205, 16'h0000);
    step();
    chk("br_addr", ram_addr, 16'h0205);
    chk("br_BW", BW, 1);
    req = 0;
    step(); step();
    chk("br_rdy", rdy, 1);
    chk("br_rdata", rdata, 16'h00A5);
    step();
    // word write 0206 <- 1234
    issue(1, 0, 16'h0206, 16'h1234);
    step();
    chk("ww2_addr", ram_addr, 16'h0206);
    req = 0;
    step(); step();
    // odd word read 0207
    issue(0, 0, 16'h0207, 16'h0000);
    step();
    chk("odd_RW", ram_RW, 0);
    req = 0;
`ifdef MEM_CTRL_ALIGN_ERR_EN
    step();
    chk("odd_rdy", rdy, 1);
    chk("odd_err", err, 1);
    chk("odd_rdata_kept", rdata, 16'h00A5);
    step();
    chk("odd_err_off", err, 0);
    chk("odd_idle", busy, 0);
`else
    chk("odd_addr", ram_addr, 16'h0206);
    step(); step();
    chk("odd_rdy", rdy, 1);
    chk("odd_rdata", rdata, 16'h1234);
    step();
`endif
    // byte write at top of address space
    issue(1, 1, 16'hFFFF, 16'h3377);
    step();
    chk("top_addr", ram_addr, 16'hFFFF);
    chk("top_din", ram_Din, 16'h0077);
    req = 0;
    step(); step();
    // req pulsed while busy is dropped
    issue(0, 0, 16'h0204, 16'h0000);
    step();
    issue(0, 0, 16'h0206, 16'h0000);
    step();
    req = 0;
    step();
    chk("pulse_rdy", rdy, 1);
    chk("pulse_rdata", rdata, 16'hA5EF);
    step();
    chk("pulse_idle1", busy, 0);
    step();
    chk("pulse_idle2", busy, 0);
    // req held high: read rdy every 4 cycles
    issue(0, 0, 16'h0206, 16'h0000);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("held_rdy_%0d", i), rdy, (i % 4 == 3) ? 16'd1 : 16'd0);
      if (i % 4 == 3) chk($sformatf("held_rdata_%0d", i), rdata, 16'h1234);
    end
    req = 0;
    step();
    chk("held_idle", busy, 0);
    // reset during write ACCESS
    issue(1, 0, 16'h0300, 16'hCAFE);
    step();
    chk("abort_RW_before", ram_RW, 1);
    rst_n = 0;
    #1;
    chk("abort_RW", ram_RW, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_rdata", rdata, 16'h0000);
    chk("abort_addr", ram_addr, 16'h0000);
    chk("abort_din", ram_Din, 16'h0000);
    chk("abort_BW", BW, 0);
`ifdef MEM_CTRL_ALIGN_ERR_EN
    chk("abort_err", err, 0);
`endif
    req = 0;
    step();
    chk("abort_rdy_hold", rdy, 0);
    @(negedge clk); rst_n = 1;
    #1;
    // first req after reset sampled at the next edge
    issue(0, 0, 16'h0206, 16'h0000);
    step();
    chk("post_busy", busy, 1);
    req = 0;
    step(); step();
    chk("post_rdy", rdy, 1);
    chk("post_rdata", rdata, 16'h1234);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
